spi_byte_sequencer: RTL and testbench

//  Hardware SPI byte engine for the Gigatron expansion board; replaces per-bit ctrl-code bit-banging.
//  The ctrl decoder issues one command per byte (tx data, device select, hold).
//  The block sequences MOSI/SCK/nSS over the MISO[2:0] ports in SPI mode 0, then returns the received byte.

---
 rtl/spi_seq_pkg.sv | 22 ++
 rtl/spi_byte_sequencer_if.sv | 24 ++
 rtl/spi_phase_timer.sv | 25 ++
 rtl/spi_byte_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_spi_byte_sequencer.sv | 524 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI byte sequencer.
// State encoding, idle chip-select value and DIV range check.
package spi_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_LOW  = 3'd2,
      ST_HIGH = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam logic [1:0] NSS_NONE = 2'b11;

   localparam int DIV_MIN = 1;
   localparam int DIV_MAX = 255;

   function automatic bit div_legal(input int d);
      return (d >= DIV_MIN) && (d <= DIV_MAX);
   endfunction

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Host-side command/response bundle of the SPI byte sequencer.
// master = ctrl-code decoder side, slave = sequencer side.
interface spi_byte_sequencer_if;

   logic       CMD_VALID;
   logic       CMD_READY;
   logic [7:0] CMD_TX;
   logic [1:0] CMD_SS;
   logic       CMD_HOLD;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       BUSY;

   modport master (
      output CMD_VALID, CMD_TX, CMD_SS, CMD_HOLD,
      input  CMD_READY, RX_DATA, RX_VALID, BUSY
   );

   modport slave (
      input  CMD_VALID, CMD_TX, CMD_SS, CMD_HOLD,
      output CMD_READY, RX_DATA, RX_VALID, BUSY
   );

endinterface

// File: rtl/spi_phase_timer.sv
// SCK half-period timer: counts 0..div-1, pulses phase_done on the last
// count and wraps; held at zero while restart is high.
module spi_phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   input  logic [7:0] div,
   output logic       phase_done
);

   logic [7:0] cnt_q, cnt_d;

   assign phase_done = (cnt_q == div - 8'd1);

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (restart || phase_done) cnt_d = 8'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spi_byte_sequencer.sv
// SPI mode-0 byte engine: one command per byte, returns the received byte.
// Optional macro SPI_LSB_FIRST_EN adds CFG_LSB for LSB-first transfers.
module spi_byte_sequencer
   import spi_seq_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic       CLK,
   input  logic       RESET,
`ifdef SPI_LSB_FIRST_EN
   input  logic       CFG_LSB,
`endif
   spi_byte_sequencer_if.slave bus,
   input  logic [2:0] MISO,
   output logic       MOSI,
   output logic       SCK,
   output logic [1:0] nSS
);

   localparam logic [7:0] DIV_W = 8'(DIV);

   if (!div_legal(DIV)) begin : g_div_check
      $error("spi_byte_sequencer: DIV must be within 1..255");
   end

   state_e     state_q, state_d;
   logic [7:0] tx_q, tx_d;
   logic [1:0] ss_q, ss_d;
   logic       hold_q, hold_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_q, bit_d;
   logic       sck_q, sck_d;
   logic       mosi_q, mosi_d;
   logic [1:0] nss_q, nss_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       busy_q, busy_d;
   logic       ready_q, ready_d;
   logic       lsb;
   logic       hs;
   logic       phase_done;
   logic       miso_bit;
   logic       first_bit;
   logic [7:0] next_tx;

`ifdef SPI_LSB_FIRST_EN
   logic lsb_q, lsb_d;
   assign lsb = lsb_q;
`else
   assign lsb = 1'b0;
`endif

   assign hs        = bus.CMD_VALID & ready_q;
   assign first_bit = lsb ? tx_q[0] : tx_q[7];
   assign next_tx   = lsb ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};

   // Device select follows the registered nSS, never the live command.
   always_comb begin
      unique case (1'b1)
         (nss_q == NSS_NONE): miso_bit = MISO[2];
         !nss_q[0]:           miso_bit = MISO[0];
         default:             miso_bit = MISO[1];
      endcase
   end

   spi_phase_timer u_timer (
      .clk        (CLK),
      .rst        (RESET),
      .restart    ((state_q != ST_LOW) && (state_q != ST_HIGH)),
      .div        (DIV_W),
      .phase_done (phase_done)
   );

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      ss_d       = ss_q;
      hold_d     = hold_q;
      shift_d    = shift_q;
      bit_d      = bit_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      nss_d      = nss_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      busy_d     = busy_q;
      ready_d    = ready_q;
`ifdef SPI_LSB_FIRST_EN
      lsb_d      = lsb_q;
`endif
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (hs) begin
               state_d = ST_LOAD;
               tx_d    = bus.CMD_TX;
               ss_d    = bus.CMD_SS;
               hold_d  = bus.CMD_HOLD;
               busy_d  = 1'b1;
               ready_d = 1'b0;
`ifdef SPI_LSB_FIRST_EN
               lsb_d   = CFG_LSB;
`endif
            end
         end
         ST_LOAD: begin
            state_d = ST_LOW;
            nss_d   = ss_q;
            mosi_d  = first_bit;
            tx_d    = next_tx;
            bit_d   = 3'd0;
         end
         ST_LOW: begin
            if (phase_done) begin
               state_d = ST_HIGH;
               sck_d   = 1'b1;
               shift_d = lsb ? {miso_bit, shift_q[7:1]}
                             : {shift_q[6:0], miso_bit};
            end
         end
         ST_HIGH: begin
            if (phase_done) begin
               sck_d = 1'b0;
               if (bit_q == 3'd7) begin
                  state_d    = ST_DONE;
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
                  nss_d      = hold_q ? nss_q : NSS_NONE;
                  busy_d     = 1'b0;
                  ready_d    = 1'b1;
               end else begin
                  state_d = ST_LOW;
                  bit_d   = bit_q + 3'd1;
                  mosi_d  = first_bit;
                  tx_d    = next_tx;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         tx_q       <= 8'h00;
         ss_q       <= NSS_NONE;
         hold_q     <= 1'b0;
         shift_q    <= 8'h00;
         bit_q      <= 3'd0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         nss_q      <= NSS_NONE;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
`ifdef SPI_LSB_FIRST_EN
         lsb_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         ss_q       <= ss_d;
         hold_q     <= hold_d;
         shift_q    <= shift_d;
         bit_q      <= bit_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         nss_q      <= nss_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
`ifdef SPI_LSB_FIRST_EN
         lsb_q      <= lsb_d;
`endif
      end
   end

   // An abort keeps the last good byte; a reset while idle clears it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (!busy_q) rx_data_q <= 8'h00;
      end else begin
         rx_data_q <= rx_data_d;
      end
   end

   assign bus.CMD_READY = ready_q;
   assign bus.RX_DATA   = rx_data_q;
   assign bus.RX_VALID  = rx_valid_q;
   assign bus.BUSY      = busy_q;
   assign MOSI          = mosi_q;
   assign SCK           = sck_q;
   assign nSS           = nss_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Self-checking bench for spi_byte_sequencer: randomized bytes against
// a behavioural SPI slave and byte-level model.
module tb_spi_byte_sequencer;

   localparam int DIV  = 2;
   localparam int LAT  = 2 + 16 * DIV;
   localparam int LAT1 = 2 + 16 * 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit lsb0 = 1'b0;
   bit lsb1 = 1'b0;
   logic [7:0] exp_last = 8'h00;

   spi_byte_sequencer_if bus ();
   spi_byte_sequencer_if bus1 ();

   logic [2:0] miso, miso1;
   logic       mosi, mosi1, sck, sck1;
   logic [1:0] nss, nss1;

   spi_byte_sequencer #(.DIV(DIV)) dut (
      .CLK   (clk),
      .RESET (rst),
`ifdef SPI_LSB_FIRST_EN
      .CFG_LSB (lsb0),
`endif
      .bus   (bus),
      .MISO  (miso),
      .MOSI  (mosi),
      .SCK   (sck),
      .nSS   (nss)
   );

   spi_byte_sequencer #(.DIV(1)) dut1 (
      .CLK   (clk),
      .RESET (rst),
`ifdef SPI_LSB_FIRST_EN
      .CFG_LSB (lsb1),
`endif
      .bus   (bus1),
      .MISO  (miso1),
      .MOSI  (mosi1),
      .SCK   (sck1),
      .nSS   (nss1)
   );

   // Behavioural slaves: each line shifts its byte out MSB first,
   // presenting the next bit after every SCK rise.
   logic [7:0] sl [3];
   int         rises = 0;
   bit         mosi_log [$];
   logic [1:0] nss_log [$];
   logic [7:0] sl1;
   int         rises1 = 0;
   bit         mosi_log1 [$];

   always @(posedge sck) begin
      mosi_log.push_back(mosi);
      nss_log.push_back(nss);
      rises = rises + 1;
   end

   always @(posedge sck1) begin
      mosi_log1.push_back(mosi1);
      rises1 = rises1 + 1;
   end

   always_comb begin
      miso = 3'b000;
      for (int i = 0; i < 3; i++)
         if (rises < 8) miso[i] = sl[i][3'(7 - rises)];
   end

   always_comb begin
      miso1 = 3'b000;
      if (rises1 < 8) miso1[0] = sl1[3'(7 - rises1)];
   end

   function automatic int model_line(input logic [1:0] ss);
      if (ss == 2'b11) return 2;
      if (ss[0] == 1'b0) return 0;
      return 1;
   endfunction

   // Received byte given the slave byte (sent MSB first) and bit order.
   function automatic logic [7:0] model_rx(input logic [7:0] sb, input bit lsb);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (lsb) r[i] = sb[7 - i];
         else     r[7 - i] = sb[7 - i];
      end
      return r;
   endfunction

   // MOSI bits in wire order, first bit packed into bit 7.
   function automatic logic [7:0] model_mosi(input logic [7:0] tx, input bit lsb);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7 - i] = lsb ? tx[i] : tx[7 - i];
      return r;
   endfunction

   function automatic logic [7:0] pack_log(input bit q [$]);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 8 && i < q.size(); i++) r[7 - i] = q[i];
      return r;
   endfunction

   task automatic xfer(input logic [7:0] tx, input logic [1:0] ss,
                       input bit hold, input bit lsb,
                       output int lat, output logic [7:0] rx);
      int w;
      int t0;
      bit got;
      w = 0;
      @(negedge clk);
      while (!bus.CMD_READY && w < 100) begin
         @(negedge clk);
         w++;
      end
      rises = 0;
      mosi_log.delete();
      nss_log.delete();
      lsb0 = lsb;
      bus.CMD_TX = tx;
      bus.CMD_SS = ss;
      bus.CMD_HOLD = hold;
      bus.CMD_VALID = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      lat = -1;
      rx = 8'hxx;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         if (bus.RX_VALID) begin
            lat = cyc - t0;
            rx = bus.RX_DATA;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.CMD_VALID = 1'b0;
      bus.CMD_TX = 8'h00;
      bus.CMD_SS = 2'b11;
      bus.CMD_HOLD = 1'b0;
      bus1.CMD_VALID = 1'b0;
      bus1.CMD_TX = 8'h00;
      bus1.CMD_SS = 2'b11;
      bus1.CMD_HOLD = 1'b0;
      sl[0] = 8'h00;
      sl[1] = 8'h00;
      sl[2] = 8'h00;
      sl1 = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({nss, sck, mosi, bus.CMD_READY, bus.BUSY, bus.RX_VALID} !== 7'b1100100) begin
            errors++;
            $display("FAIL reset_idle: nss,sck,mosi,rdy,busy,rxv=%b want 1100100",
                     {nss, sck, mosi, bus.CMD_READY, bus.BUSY, bus.RX_VALID});
         end
         checks++;
         if (bus.RX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h want 00", bus.RX_DATA);
         end
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [7:0] rx;
      int bad;
      sl[0] = 8'h3C;
      sl[1] = 8'hC3;
      sl[2] = 8'h96;
      xfer(8'hA5, 2'b10, 1'b0, 1'b0, lat, rx);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
      end
      checks++;
      if (rx !== 8'h3C) begin
         errors++;
         $display("FAIL basic_rx: got %h want 3c", rx);
      end
      checks++;
      if (mosi_log.size() !== 8 || pack_log(mosi_log) !== 8'b10100101) begin
         errors++;
         $display("FAIL basic_mosi: got %b (%0d bits) want 10100101",
                  pack_log(mosi_log), mosi_log.size());
      end
      bad = 0;
      foreach (nss_log[i]) if (nss_log[i] !== 2'b10) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL basic_nss_during: %0d rises with wrong nSS, want 0", bad);
      end
      checks++;
      if (bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_done: got %b want 0", bus.BUSY);
      end
      @(negedge clk);
      checks++;
      if (nss !== 2'b11) begin
         errors++;
         $display("FAIL basic_nss_after: got %b want 11", nss);
      end
      exp_last = 8'h3C;
   endtask

   task automatic test_hold_back_to_back();
      logic [7:0] r1, r2;
      int t0, c1, c2, n, bad;
      bit load_busy;
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      @(negedge clk);
      rises = 0;
      mosi_log.delete();
      sl[1] = r1;
      sl[0] = ~r1;
      lsb0 = 1'b0;
      bus.CMD_TX = 8'h01;
      bus.CMD_SS = 2'b01;
      bus.CMD_HOLD = 1'b1;
      bus.CMD_VALID = 1'b1;
      t0 = cyc;
      c1 = -1;
      c2 = -1;
      n = 0;
      bad = 0;
      load_busy = 1'b0;
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      for (int k = 0; k < 300 && n < 2; k++) begin
         if (cyc >= t0 + 2 && !(n == 1 && bus.RX_VALID) && nss !== 2'b01) bad++;
         if (c1 >= 0 && cyc == c1 + 1) load_busy = bus.BUSY;
         if (bus.RX_VALID) begin
            if (n == 0) begin
               c1 = cyc;
               checks++;
               if (bus.RX_DATA !== r1) begin
                  errors++;
                  $display("FAIL hold_rx1: got %h want %h", bus.RX_DATA, r1);
               end
               rises = 0;
               sl[1] = r2;
               bus.CMD_TX = 8'h02;
               bus.CMD_HOLD = 1'b0;
               bus.CMD_VALID = 1'b1;
            end else begin
               c2 = cyc;
               checks++;
               if (bus.RX_DATA !== r2) begin
                  errors++;
                  $display("FAIL hold_rx2: got %h want %h", bus.RX_DATA, r2);
               end
               checks++;
               if (nss !== 2'b11) begin
                  errors++;
                  $display("FAIL hold_release: got %b want 11", nss);
               end
            end
            n++;
         end
         @(negedge clk);
         if (n == 1 && cyc == c1 + 1) bus.CMD_VALID = 1'b0;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL hold_nss: %0d cycles with nSS != 01, want 0", bad);
      end
      checks++;
      if (load_busy !== 1'b1) begin
         errors++;
         $display("FAIL hold_load_follows_done: busy=%b want 1", load_busy);
      end
      checks++;
      if (c1 - t0 !== LAT || c2 - c1 !== LAT) begin
         errors++;
         $display("FAIL hold_spacing: got %0d/%0d want %0d/%0d", c1 - t0, c2 - c1, LAT, LAT);
      end
      exp_last = r2;
   endtask

   task automatic test_busy_reject();
      int acc [$];
      int rxc [2];
      logic [7:0] rxd [2];
      int n;
      @(negedge clk);
      while (!bus.CMD_READY) @(negedge clk);
      rises = 0;
      sl[0] = 8'h00;
      sl[1] = 8'h00;
      sl[2] = 8'hFF;
      lsb0 = 1'b0;
      bus.CMD_TX = 8'($urandom);
      bus.CMD_SS = 2'b11;
      bus.CMD_HOLD = 1'b0;
      bus.CMD_VALID = 1'b1;
      n = 0;
      rxc[0] = -1;
      rxc[1] = -1;
      for (int k = 0; k < 300 && n < 2; k++) begin
         if (acc.size() >= 2) bus.CMD_VALID = 1'b0;
         if (bus.CMD_VALID && bus.CMD_READY) acc.push_back(cyc);
         if (bus.RX_VALID) begin
            rxc[n] = cyc;
            rxd[n] = bus.RX_DATA;
            n++;
            rises = 0;
         end
         @(negedge clk);
      end
      bus.CMD_VALID = 1'b0;
      checks++;
      if (acc.size() !== 2 || rxc[0] < 0 || acc[1] !== rxc[0]) begin
         errors++;
         $display("FAIL busy_reject_accepts: %0d accepts, 2nd at %0d, done at %0d",
                  acc.size(), (acc.size() > 1) ? acc[1] : -1, rxc[0]);
      end
      checks++;
      if (n !== 2 || rxd[0] !== 8'hFF || rxd[1] !== 8'hFF) begin
         errors++;
         $display("FAIL busy_reject_rx: %0d bytes, got %h %h want ff ff", n, rxd[0], rxd[1]);
      end
      checks++;
      if (acc.size() < 2 || rxc[0] - acc[0] !== LAT || rxc[1] - acc[1] !== LAT) begin
         errors++;
         $display("FAIL busy_reject_latency: got %0d %0d want %0d",
                  rxc[0] - ((acc.size() > 0) ? acc[0] : 0),
                  rxc[1] - ((acc.size() > 1) ? acc[1] : 0), LAT);
      end
      exp_last = 8'hFF;
   endtask

   task automatic test_random();
      int lat;
      logic [7:0] rx, tx, exp;
      logic [1:0] ss;
      bit hold, lsb;
      int bad;
      for (int it = 0; it < 10; it++) begin
         tx = 8'($urandom);
         ss = 2'($urandom_range(0, 3));
         hold = 1'($urandom_range(0, 1));
`ifdef SPI_LSB_FIRST_EN
         lsb = 1'($urandom_range(0, 1));
`else
         lsb = 1'b0;
`endif
         for (int i = 0; i < 3; i++) sl[i] = 8'($urandom);
         exp = model_rx(sl[model_line(ss)], lsb);
         xfer(tx, ss, hold, lsb, lat, rx);
         checks++;
         if (rx !== exp || lat !== LAT) begin
            errors++;
            $display("FAIL random_rx[%0d]: got %h lat %0d want %h lat %0d", it, rx, lat, exp, LAT);
         end
         checks++;
         if (mosi_log.size() !== 8 || pack_log(mosi_log) !== model_mosi(tx, lsb)) begin
            errors++;
            $display("FAIL random_mosi[%0d]: got %b want %b", it, pack_log(mosi_log),
                     model_mosi(tx, lsb));
         end
         bad = 0;
         foreach (nss_log[i]) if (nss_log[i] !== ss) bad++;
         @(negedge clk);
         checks++;
         if (bad !== 0 || nss !== (hold ? ss : 2'b11)) begin
            errors++;
            $display("FAIL random_nss[%0d]: %0d bad rises, after=%b want %b", it, bad, nss,
                     hold ? ss : 2'b11);
         end
         exp_last = exp;
      end
   endtask

   task automatic test_reset_abort();
      int w, pulses;
      @(negedge clk);
      while (!bus.CMD_READY) @(negedge clk);
      rises = 0;
      sl[0] = 8'($urandom);
      lsb0 = 1'b0;
      bus.CMD_TX = 8'($urandom);
      bus.CMD_SS = 2'b10;
      bus.CMD_HOLD = 1'b0;
      bus.CMD_VALID = 1'b1;
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      w = 0;
      while (rises < 5 && w < 200) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (rises !== 5 || sck !== 1'b1) begin
         errors++;
         $display("FAIL abort_reach_5th_rise: rises=%0d sck=%b want 5 1", rises, sck);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({sck, nss, bus.BUSY, bus.RX_VALID, bus.CMD_READY} !== 6'b011001) begin
         errors++;
         $display("FAIL abort_outputs: sck,nss,busy,rxv,rdy=%b want 011001",
                  {sck, nss, bus.BUSY, bus.RX_VALID, bus.CMD_READY});
      end
      checks++;
      if (bus.RX_DATA !== exp_last) begin
         errors++;
         $display("FAIL abort_rx_kept: got %h want %h", bus.RX_DATA, exp_last);
      end
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.RX_VALID) pulses++;
      end
      checks++;
      if (pulses !== 0 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_rx_valid: %0d pulses busy=%b want 0 0", pulses, bus.BUSY);
      end
   endtask

   task automatic test_div1();
      int t0, lat, w;
      logic [7:0] rx;
      bit got;
      @(negedge clk);
      w = 0;
      while (!bus1.CMD_READY && w < 100) begin
         @(negedge clk);
         w++;
      end
`ifdef SPI_LSB_FIRST_EN
      lsb1 = 1'b1;
`else
      lsb1 = 1'b0;
`endif
      rises1 = 0;
      mosi_log1.delete();
      sl1 = 8'h80;
      bus1.CMD_TX = 8'h80;
      bus1.CMD_SS = 2'b10;
      bus1.CMD_HOLD = 1'b0;
      bus1.CMD_VALID = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus1.CMD_VALID = 1'b0;
      lat = -1;
      rx = 8'hxx;
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
         if (bus1.RX_VALID) begin
            lat = cyc - t0;
            rx = bus1.RX_DATA;
            got = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checks++;
      if (lat !== LAT1) begin
         errors++;
         $display("FAIL div1_latency: got %0d want %0d", lat, LAT1);
      end
      checks++;
      if (rx !== model_rx(8'h80, lsb1)) begin
         errors++;
         $display("FAIL div1_rx: got %h want %h", rx, model_rx(8'h80, lsb1));
      end
      checks++;
      if (mosi_log1.size() !== 8 || pack_log(mosi_log1) !== model_mosi(8'h80, lsb1)) begin
         errors++;
         $display("FAIL div1_mosi: got %b want %b", pack_log(mosi_log1),
                  model_mosi(8'h80, lsb1));
      end
      @(negedge clk);
      checks++;
      if (nss1 !== 2'b11 || bus1.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL div1_end: nss=%b busy=%b want 11 0", nss1, bus1.BUSY);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_back_to_back();
      test_busy_reject();
      test_random();
      test_reset_abort();
      test_div1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
